// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit: access sizes,
// FSM state encoding and helpers for access legality and byte-lane selection.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int RD_LATENCY_MAX = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } lsu_state_t;

    // True when the size is reserved or the address is not naturally aligned.
    function automatic logic size_fault(input logic [1:0] size, input logic [1:0] lane);
        logic f;
        case (size)
            SZ_BYTE: f = 1'b0;
            SZ_HALF: f = lane[0];
            SZ_WORD: f = (lane != 2'b00);
            default: f = 1'b1;
        endcase
        return f;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << lane;
            SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: byte-enable synchronous write, combinational read
// of the addressed word.
module dmem_array #(
    parameter  int DEPTH_WORDS = 256,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the storage array has no reset; contents must survive a reset of the LSU.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of dmem_array: one request at a time, stores commit at
// accept, loads return the lane-extracted, sign/zero-extended value after RD_LATENCY.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int RD_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(RD_LATENCY_MAX);
    localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LATENCY - 1);

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    lsu_state_t  state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    lsu_req_t    req_q;
    logic [31:0] word_q;

    logic        accept;
    logic        req_fault;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready & ~reset;

    assign req_fault = size_fault(req_size, req_addr[1:0]) | (req_addr[31:AW+2] != '0);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        mem_be    = 4'b0000;
        mem_wdata = req_wdata;
        case (req_size)
            SZ_BYTE: mem_wdata = {4{req_wdata[7:0]}};
            SZ_HALF: mem_wdata = {2{req_wdata[15:0]}};
            default: mem_wdata = req_wdata;
        endcase
        if (accept && req_we && !req_fault) begin
            mem_be = lane_mask(req_size, req_addr[1:0]);
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .addr (req_addr[AW+1:2]),
        .be   (mem_be),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            req_q  <= '0;
            word_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                req_q  <= '{we: req_we, size: req_size, sgn: req_signed,
                           addr: req_addr, wdata: req_wdata};
                word_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (RD_LATENCY == 1) begin
                        state_nx = RESP;
                    end else begin
                        state_nx = BUSY;
                        cnt_nx   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                cnt_nx = cnt - 1'b1;
                if (cnt_nx == '0) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Response path works only from the latched request and the word read at accept.
    logic        fault_q;
    logic [1:0]  lane_q;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v;

    assign fault_q = size_fault(req_q.size, req_q.addr[1:0]) | (req_q.addr[31:AW+2] != '0);
    assign lane_q  = req_q.addr[1:0];
    assign byte_v  = word_q[{lane_q, 3'b000} +: 8];
    assign half_v  = lane_q[1] ? word_q[31:16] : word_q[15:0];

    always_comb begin
        load_v = word_q;
        case (req_q.size)
            SZ_BYTE: load_v = {{24{req_q.sgn & byte_v[7]}}, byte_v};
            SZ_HALF: load_v = {{16{req_q.sgn & half_v[15]}}, half_v};
            default: load_v = word_q;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign rsp_err   = rsp_valid & fault_q;
    assign rsp_rdata = (rsp_valid && !fault_q && !req_q.we) ? load_v : 32'h0;

    // Store data and word-index bits of the latched request are kept for visibility only.
    logic unused_bits;
    assign unused_bits = ^{req_q.wdata, req_q.addr[AW+1:2]};

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: three instances (RD_LATENCY 1, 3, 4) checked against
// a byte-array reference model; a negedge monitor pops and compares every response.
module tb_dmem_lsu;
    import dmem_pkg::*;

    localparam int NI    = 3;
    localparam int DEPTH = 64;

    function automatic int lat_of(int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    logic        clk = 1'b0;
    logic        reset      [NI];
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic        req_we     [NI];
    logic [1:0]  req_size   [NI];
    logic        req_signed [NI];
    logic [31:0] req_addr   [NI];
    logic [31:0] req_wdata  [NI];
    logic        rsp_valid  [NI];
    logic        rsp_ready  [NI];
    logic [31:0] rsp_rdata  [NI];
    logic        rsp_err    [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_lsu #(
            .DEPTH_WORDS(DEPTH),
            .RD_LATENCY (lat_of(g))
        ) u_dut (
            .clk       (clk),
            .reset     (reset[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_size  (req_size[g]),
            .req_signed(req_signed[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );
    end

    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    byte unsigned mem_m [NI][DEPTH*4];
    int           checks = 0;
    int           errors = 0;
    int           cyc    = 0;
    bit           hold_ready [NI];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory as a flat little-endian byte array.
    function automatic exp_t model(int i, logic we, logic [1:0] sz, logic sg,
                                   logic [31:0] a, logic [31:0] wd);
        exp_t        e;
        int          n;
        logic [31:0] v;
        e.inst  = i;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        if (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
            || a >= DEPTH*4) begin
            e.err = 1'b1;
            return e;
        end
        n = 1 << sz;
        if (we) begin
            for (int k = 0; k < n; k++) mem_m[i][int'(a) + k] = wd[8*k +: 8];
        end else begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v = v | (32'(mem_m[i][int'(a) + k]) << (8*k));
            if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            e.rdata = v;
        end
        return e;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NI; i++)
            rsp_ready[i] = hold_ready[i] ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: latency, hold stability, zero-when-idle and scoreboard comparison.
    int          acc_at [NI];
    bit          seen   [NI];
    bit          held   [NI];
    logic [31:0] hd     [NI];
    logic        he     [NI];

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (reset[i]) begin
                seen[i] = 1'b0;
                held[i] = 1'b0;
            end else if (rsp_valid[i]) begin
                check("req_ready_in_resp", req_ready[i], 0);
                if (!seen[i]) begin
                    seen[i] = 1'b1;
                    check("latency", 32'(cyc - acc_at[i] + 1), 32'(lat_of(i)));
                    if (exp_q.size() == 0 || exp_q[0].inst != i) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: inst %0d got rsp_valid=1 expected none", i);
                    end
                end
                if (held[i]) begin
                    check("hold_rdata", rsp_rdata[i], hd[i]);
                    check("hold_err", rsp_err[i], he[i]);
                end
                if (rsp_ready[i]) begin
                    seen[i] = 1'b0;
                    held[i] = 1'b0;
                    if (exp_q.size() != 0 && exp_q[0].inst == i) begin
                        mon_e = exp_q.pop_front();
                        check("rsp_rdata", rsp_rdata[i], mon_e.rdata);
                        check("rsp_err", rsp_err[i], mon_e.err);
                    end
                end else begin
                    held[i] = 1'b1;
                    hd[i]   = rsp_rdata[i];
                    he[i]   = rsp_err[i];
                end
            end else begin
                check("idle_rdata", rsp_rdata[i], 0);
                check("idle_err", rsp_err[i], 0);
                seen[i] = 1'b0;
                held[i] = 1'b0;
            end
            if (!reset[i] && req_valid[i] && req_ready[i]) acc_at[i] = cyc + 1;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("rsp_timeout", 32'(exp_q.size()), 0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int i, logic we, logic [1:0] sz, logic sg, logic [31:0] a,
                         logic [31:0] wd, bit use_exp = 0, logic [31:0] er = 0,
                         logic ee = 0, bit wait_rsp = 1);
        exp_t e;
        int   n = 0;
        e = model(i, we, sz, sg, a, wd);
        if (use_exp) begin
            e.rdata = er;
            e.err   = ee;
        end
        exp_q.push_back(e);
        req_valid[i]  = 1'b1;
        req_we[i]     = we;
        req_size[i]   = sz;
        req_signed[i] = sg;
        req_addr[i]   = a;
        req_wdata[i]  = wd;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 100);
        if (!req_ready[i]) check("accept_timeout", req_ready[i], 1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        if (wait_rsp) wait_idle();
    endtask

    initial begin
        int          inst;
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < NI; i++) begin
            reset[i]      = 1'b1;
            req_valid[i]  = 1'b0;
            req_we[i]     = 1'b0;
            req_size[i]   = 2'b00;
            req_signed[i] = 1'b0;
            req_addr[i]   = 32'h0;
            req_wdata[i]  = 32'h0;
            hold_ready[i] = 1'b0;
            acc_at[i]     = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) reset[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("reset_req_ready", req_ready[i], 1);
            check("reset_rsp_valid", rsp_valid[i], 0);
            check("reset_rsp_rdata", rsp_rdata[i], 0);
            check("reset_rsp_err", rsp_err[i], 0);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < NI; i++)
            for (int w = 0; w < DEPTH; w++) issue(i, 1'b1, SZ_WORD, 1'b0, 32'(w*4), $urandom);

        // Word store/load round trip, then byte store with signed/unsigned reads.
        issue(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 1, 32'h0, 1'b0);
        issue(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
        issue(0, 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h1234_5680, 1, 32'h0, 1'b0);
        issue(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1, 32'hDEAD_80EF, 1'b0);
        issue(0, 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 1, 32'hFFFF_FF80, 1'b0);
        issue(0, 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, 1, 32'h0000_0080, 1'b0);

        // Faulting accesses leave memory untouched.
        issue(0, 1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, 1, 32'h0, 1'b1);
        issue(0, 1'b0, SZ_HALF, 1'b0, 32'h01, 32'h0, 1, 32'h0, 1'b1);
        issue(0, 1'b0, SZ_RSVD, 1'b0, 32'h10, 32'h0, 1, 32'h0, 1'b1);
        issue(0, 1'b1, SZ_WORD, 1'b0, 32'(DEPTH*4), 32'h5555_5555, 1, 32'h0, 1'b1);
        issue(0, 1'b1, SZ_WORD, 1'b0, 32'h13, 32'h6666_6666, 1, 32'h0, 1'b1);
        issue(0, 1'b1, SZ_HALF, 1'b0, 32'h01, 32'h7777_7777, 1, 32'h0, 1'b1);
        issue(0, 1'b1, SZ_RSVD, 1'b0, 32'h10, 32'h8888_8888, 1, 32'h0, 1'b1);
        issue(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1, 32'hDEAD_80EF, 1'b0);
        issue(0, 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0);
        issue(0, 1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0);

        // Latency 3: signed half load with the consumer stalling.
        issue(1, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h8001_1234, 1, 32'h0, 1'b0);
        hold_ready[1] = 1'b1;
        issue(1, 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 1, 32'hFFFF_8001, 1'b0, 0);
        repeat (8) @(posedge clk);
        #1;
        hold_ready[1] = 1'b0;
        wait_idle();

        // Latency 4: reset two cycles after a store accept drops the response.
        issue(2, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'hCAFE_F00D, 1, 32'h0, 1'b0, 0);
        @(posedge clk);
        #1;
        reset[2]     = 1'b1;
        exp_q.delete();
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_size[2]  = SZ_WORD;
        req_addr[2]  = 32'h24;
        req_wdata[2] = 32'h0BAD_0BAD;
        repeat (2) @(posedge clk);
        #1;
        reset[2]     = 1'b0;
        req_valid[2] = 1'b0;
        @(negedge clk);
        check("post_reset_req_ready", req_ready[2], 1);
        check("post_reset_rsp_valid", rsp_valid[2], 0);
        repeat (6) @(posedge clk);
        #1;
        issue(2, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1, 32'hCAFE_F00D, 1'b0);
        issue(2, 1'b0, SZ_WORD, 1'b0, 32'h24, 32'h0);

        for (int n = 0; n < 450; n++) begin
            inst = $urandom_range(0, NI-1);
            sz   = 2'($urandom_range(0, 3));
            if (sz == 2'b11 && $urandom_range(0, 1) == 1) sz = SZ_WORD;
            if ($urandom_range(0, 9) == 0) a = $urandom_range(DEPTH*4 - 8, DEPTH*4 + 8);
            else                           a = $urandom_range(0, 63);
            if (sz != 2'b11 && $urandom_range(0, 1) == 1) a = a & ~32'((1 << sz) - 1);
            issue(inst, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
